ps2_key_receiver: RTL
=====================

PS2_KEY_RECEIVER -- requirements
Module: ps2_key_receiver

Interface
REQ-001 SHALL have parameter FILTER_LEN, 8, number of consecutive equal samples required to accept a new ps2_clk level.
REQ-002 SHALL have parameter FRAME_TIMEOUT, 50000, maximum clk cycles between ps2_clk falling edges inside a frame.
REQ-003 SHALL have parameter HOLD_CYCLES, 5000000, clk cycles a received code stays on key before it reverts to KP_INVALID.
REQ-004 SHALL have port clk, input, 1, system clock (50 MHz nominal).
REQ-005 SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have port ps2_clk, input, 1, asynchronous PS/2 device clock.
REQ-007 SHALL have port ps2_data, input, 1, asynchronous PS/2 device data.
REQ-008 SHALL have port key, output, 8, held keycode for the alarm controller; KP_INVALID when idle.
REQ-009 SHALL have port key_valid, output, 1, one-cycle strobe when key takes a newly received code.
REQ-010 SHALL have port parity_err, output, 1, one-cycle strobe on a frame with bad odd parity.
REQ-011 SHALL have port frame_err, output, 1, one-cycle strobe on a bad start/stop bit or a timeout.

Function
REQ-012 SHALL pass ps2_clk and ps2_data through two synchronizer flops each before any other use.
REQ-013 SHALL accept a new filtered ps2_clk level only after FILTER_LEN consecutive equal synchronized samples.
REQ-014 SHALL sample synchronized ps2_data on each filtered ps2_clk falling edge; no other edge shall advance the FSM.
REQ-015 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-016 In IDLE, SHALL go to DATA on an edge with data=0, and assert frame_err and stay in IDLE on an edge with data=1.
REQ-017 In DATA, SHALL shift bits LSB first and go to PARITY after exactly 8 edges.
REQ-018 In PARITY, SHALL capture the parity bit and go to STOP on the next edge.
REQ-019 In STOP, SHALL deliver the frame if stop=1 and odd parity over 8 data bits plus parity holds.
REQ-020 SHALL, if stop=0, assert frame_err and discard the frame; parity is not checked.
REQ-021 SHALL, if stop=1 and parity fails, assert parity_err and discard the frame.
REQ-022 SHALL return to IDLE after STOP in all cases.
REQ-023 SHALL, in DATA, PARITY or STOP, abort to IDLE, assert frame_err and discard partial data if FRAME_TIMEOUT cycles pass with no edge.
REQ-024 SHALL, on delivery, drive key with the received byte on the cycle after the stop edge, pulse key_valid for that cycle and reload the hold counter.
REQ-025 SHALL, if the received byte is 8'h00 (KP_INVALID), deliver it and pulse key_valid like any other code.
REQ-026 SHALL hold key until the next delivery or HOLD_CYCLES expiry, whichever comes first; on expiry key becomes KP_INVALID with no strobe.
REQ-027 SHALL, when a delivery and hold expiry fall on the same cycle, apply the delivery.
REQ-028 SHALL pass break prefix KP_KEY_RELEASED (8'hF0) and extended prefix 8'hE0 through unchanged as ordinary codes, so the consumer sees press code, F0, release code, then KP_INVALID after hold expiry.
REQ-029 SHALL keep the strobes mutually exclusive, with at most one per frame.

Reset
REQ-030 SHALL, on reset, set state IDLE, key=KP_INVALID, key_valid=0, parity_err=0, frame_err=0, shift register 0, and the bit, timeout and hold counters 0.
REQ-031 SHALL set filtered ps2_clk and synchronizers to 1 (idle bus level) on reset.
REQ-032 SHALL, if reset is asserted mid-frame, discard the partial frame with no strobe; the next start edge after reset begins a fresh frame.

Structure
REQ-033 SHALL take KP_INVALID (8'h00), KP_KEY_RELEASED (8'hF0), KP_EXTENDED (8'hE0), keypad codes (KP_0 8'h70 .. KP_9 8'h7D, KP_STAR 8'h7C, KP_MINUS 8'h7B) and the FSM state encoding from the shared keycodes package.
REQ-034 SHALL place the synchronizer, FILTER_LEN glitch filter and falling-edge detect in one sub-module, ps2_sync_filter, with outputs filt_clk_fall and sync_data.

Verification
REQ-035 Frame 0x70 (data bits, parity 0, stop 1) at 12.5 kHz -> key=8'h70, one key_valid pulse; key=8'h00 after HOLD_CYCLES.
REQ-036 Sequence 0x70, 0xF0, 0x70 -> three key_valid pulses with key 70, F0, 70 in order, then KP_INVALID after hold.
REQ-037 Frame 0x7C with parity bit flipped -> one parity_err pulse, no key_valid, key unchanged.
REQ-038 Frame 0x7B with stop=0 -> one frame_err pulse, no key_valid; next valid frame 0x69 -> key=8'h69.
REQ-039 Stop ps2_clk after 4 data bits -> frame_err exactly FRAME_TIMEOUT cycles after the last edge, FSM in IDLE; next frame 0x72 -> key=8'h72.
REQ-040 Glitch pulses on ps2_clk shorter than FILTER_LEN cycles mid-frame -> ignored, frame 0x75 delivered; reset asserted mid-frame -> no strobe, key=KP_INVALID.

Source files
------------

// File: rtl/ps2_key_receiver_pkg.sv
// Shared keycodes and receiver FSM encoding for the PS/2 keypad path.
// Keypad scan codes are set 2, as sent by the keypad.
package ps2_key_receiver_pkg;

    localparam logic [7:0] KP_INVALID      = 8'h00;
    localparam logic [7:0] KP_KEY_RELEASED = 8'hF0;
    localparam logic [7:0] KP_EXTENDED     = 8'hE0;
    localparam logic [7:0] KP_0            = 8'h70;
    localparam logic [7:0] KP_1            = 8'h69;
    localparam logic [7:0] KP_2            = 8'h72;
    localparam logic [7:0] KP_3            = 8'h7A;
    localparam logic [7:0] KP_4            = 8'h6B;
    localparam logic [7:0] KP_5            = 8'h73;
    localparam logic [7:0] KP_6            = 8'h74;
    localparam logic [7:0] KP_7            = 8'h6C;
    localparam logic [7:0] KP_8            = 8'h75;
    localparam logic [7:0] KP_9            = 8'h7D;
    localparam logic [7:0] KP_STAR         = 8'h7C;
    localparam logic [7:0] KP_MINUS        = 8'h7B;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } rx_state_e;

    // Odd parity holds when data bits plus parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Synchronizes ps2_clk/ps2_data, deglitches ps2_clk and flags its filtered falling edges.
module ps2_sync_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic filt_clk_fall,
    output logic sync_data
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic          filt_clk_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q    <= 2'b11;
            data_sync_q   <= 2'b11;
            filt_clk_q    <= 1'b1;
            cnt_q         <= '0;
            filt_clk_fall <= 1'b0;
        end else begin
            clk_sync_q    <= {clk_sync_q[0], ps2_clk};
            data_sync_q   <= {data_sync_q[0], ps2_data};
            filt_clk_fall <= 1'b0;
            // cnt_q counts consecutive samples that disagree with the filtered level.
            if (clk_sync_q[1] == filt_clk_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_clk_q    <= clk_sync_q[1];
                cnt_q         <= '0;
                filt_clk_fall <= filt_clk_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign sync_data = data_sync_q[1];

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keypad frame receiver: decodes 11-bit frames and holds the last code on key.
module ps2_key_receiver
    import ps2_key_receiver_pkg::*;
#(
    parameter int unsigned FILTER_LEN    = 8,
    parameter int unsigned FRAME_TIMEOUT = 50000,
    parameter int unsigned HOLD_CYCLES   = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key,
    output logic       key_valid,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int unsigned TW = $clog2(FRAME_TIMEOUT + 1);
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

    logic          fall;
    logic          sync_data;
    rx_state_e     state_q;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt_q;
    logic          parity_q;
    logic [TW-1:0] tmo_q;
    logic [HW-1:0] hold_q;

    ps2_sync_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_sync_filter (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .filt_clk_fall(fall),
        .sync_data    (sync_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            parity_q   <= 1'b0;
            tmo_q      <= '0;
            hold_q     <= '0;
            key        <= KP_INVALID;
            key_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            key_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            if (hold_q != '0) begin
                hold_q <= hold_q - 1'b1;
                if (hold_q == HW'(1)) key <= KP_INVALID;
            end

            if (state_q == StIdle || fall) tmo_q <= '0;
            else                           tmo_q <= tmo_q + 1'b1;

            if (fall) begin
                case (state_q)
                    StIdle: begin
                        if (!sync_data) begin
                            state_q   <= StData;
                            bit_cnt_q <= '0;
                            shift_q   <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    StData: begin
                        shift_q   <= {sync_data, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) state_q <= StParity;
                    end
                    StParity: begin
                        parity_q <= sync_data;
                        state_q  <= StStop;
                    end
                    StStop: begin
                        state_q <= StIdle;
                        if (!sync_data) begin
                            frame_err <= 1'b1;
                        end else if (!odd_parity_ok(shift_q, parity_q)) begin
                            parity_err <= 1'b1;
                        end else begin
                            // Placed after the hold decrement so a delivery beats expiry.
                            key       <= shift_q;
                            key_valid <= 1'b1;
                            hold_q    <= HW'(HOLD_CYCLES);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end else if (state_q != StIdle && tmo_q == TW'(FRAME_TIMEOUT - 1)) begin
                state_q   <= StIdle;
                frame_err <= 1'b1;
            end
        end
    end

endmodule
